// File: rtl/chunked_adder.sv
// ---------------------------------------------------------------------------
// chunked_adder
//
// Multi-cycle unsigned adder. Two WIDTH-bit operands plus a carry-in are
// added CHUNK bits per clock. The carry between chunks is held in a register,
// so the adder hardware scales with CHUNK rather than WIDTH. Operands are
// accepted through a valid/ready handshake and the result is presented
// through a second valid/ready handshake.
//
// Build option:
//   CHUNKED_ADDER_SUB_EN  - when defined, adds the 'sub' port. sub=1 at
//                           accept computes a + ~b + 1 (cin ignored), so
//                           sum[WIDTH]=1 means "no borrow" (a >= b).
//
// Parameters:
//   WIDTH      operand width in bits (multiple of CHUNK)
//   CHUNK      bits added per clock (1..WIDTH)
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operands on a/b/cin (and sub) are valid
//   in_ready   block can accept operands (IDLE, forced 0 while in reset)
//   a, b       WIDTH-bit unsigned operands
//   cin        carry-in
//   sub        subtract select (only with CHUNKED_ADDER_SUB_EN)
//   busy       high while chunks are being added (RUN)
//   out_valid  sum is valid (DONE)
//   out_ready  consumer accepts sum
//   sum        WIDTH+1-bit result, sum[WIDTH] is carry-out
// ---------------------------------------------------------------------------
module chunked_adder #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef CHUNKED_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   sum_q;
  logic             busy_q;
  logic             out_valid_q;

  logic [WIDTH-1:0] b_eff;
  logic             carry_init;
  logic [31:0]      shamt;
  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK:0]   chunk_res;
  logic [WIDTH-1:0] chunk_mask;
  logic [WIDTH-1:0] chunk_placed;
  logic [WIDTH-1:0] sum_lo_next;

  // Operand conditioning at accept time. Subtraction is folded into the
  // captured copy of b (inverted) and a forced initial carry of 1, so the
  // chunk datapath below is a plain adder in both modes.
`ifdef CHUNKED_ADDER_SUB_EN
  always_comb begin
    b_eff      = sub ? ~b : b;
    carry_init = sub ? 1'b1 : cin;
  end
`else
  always_comb begin
    b_eff      = b;
    carry_init = cin;
  end
`endif

  // Chunk datapath. The active chunk is selected by shifting the captured
  // operands down by cnt*CHUNK, and the result bits are merged back into
  // the same bit positions of the sum with a shifted mask. Shifts are used
  // instead of variable part-selects so index widths stay clean.
  always_comb begin
    shamt        = 32'(cnt) * 32'(CHUNK);
    a_chunk      = CHUNK'(a_q >> shamt);
    b_chunk      = CHUNK'(b_q >> shamt);
    chunk_res    = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry};
    chunk_mask   = WIDTH'({CHUNK{1'b1}}) << shamt;
    chunk_placed = WIDTH'(chunk_res[CHUNK-1:0]) << shamt;
    sum_lo_next  = (sum_q[WIDTH-1:0] & ~chunk_mask) | chunk_placed;
  end

  // Control FSM and datapath registers. Reset aborts any operation in
  // flight: state returns to IDLE and the partial sum is cleared so a
  // half-built result can never be presented.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      carry       <= 1'b0;
      cnt         <= '0;
      sum_q       <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q    <= a;
            b_q    <= b_eff;
            carry  <= carry_init;
            cnt    <= '0;
            sum_q  <= '0;
            busy_q <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          carry            <= chunk_res[CHUNK];
          sum_q[WIDTH-1:0] <= sum_lo_next;
          if (cnt == LAST) begin
            // Final chunk: its carry-out becomes the top bit of the result.
            sum_q[WIDTH] <= chunk_res[CHUNK];
            busy_q       <= 1'b0;
            out_valid_q  <= 1'b1;
            state        <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          state       <= IDLE;
          busy_q      <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // in_ready is the only combinational output; it is gated by rst_n so the
  // producer never sees a ready block while reset is asserted.
  assign in_ready  = rst_n && (state == IDLE);
  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;

endmodule

// File: tb/tb_chunked_adder.sv
// ---------------------------------------------------------------------------
// tb_chunked_adder
//
// Self-checking bench for chunked_adder. The main instance uses the default
// WIDTH=8/CHUNK=2; two extra instances (WIDTH=2/CHUNK=1 and WIDTH=4/CHUNK=4)
// are swept exhaustively. Expected sums come from plain integer arithmetic.
// ---------------------------------------------------------------------------
module tb_chunked_adder;

`ifdef CHUNKED_ADDER_SUB_EN
  localparam bit SUB_ON = 1'b1;
`else
  localparam bit SUB_ON = 1'b0;
`endif

  logic clk;
  logic rst_n;

  // Main instance, WIDTH=8, CHUNK=2
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       sub;
  logic       busy;
  logic       out_valid;
  logic       out_ready;
  logic [8:0] sum;

  // WIDTH=2, CHUNK=1 instance
  logic       v2, r2, c2, busy2, ov2, ordy2;
  logic [1:0] a2, b2;
  logic [2:0] s2;

  // WIDTH=4, CHUNK=4 instance
  logic       v4, r4, c4, busy4, ov4, ordy4;
  logic [3:0] a4, b4;
  logic [4:0] s4;

  int n_asserts = 0;
  int n_fail    = 0;

  chunked_adder #(.WIDTH(8), .CHUNK(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef CHUNKED_ADDER_SUB_EN
    .sub       (sub),
`endif
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum)
  );

  chunked_adder #(.WIDTH(2), .CHUNK(1)) dut_w2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (v2),
    .in_ready  (r2),
    .a         (a2),
    .b         (b2),
    .cin       (c2),
`ifdef CHUNKED_ADDER_SUB_EN
    .sub       (1'b0),
`endif
    .busy      (busy2),
    .out_valid (ov2),
    .out_ready (ordy2),
    .sum       (s2)
  );

  chunked_adder #(.WIDTH(4), .CHUNK(4)) dut_w4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (v4),
    .in_ready  (r4),
    .a         (a4),
    .b         (b4),
    .cin       (c4),
`ifdef CHUNKED_ADDER_SUB_EN
    .sub       (1'b0),
`endif
    .busy      (busy4),
    .out_valid (ov4),
    .out_ready (ordy4),
    .sum       (s4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so a stuck run still ends.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference: the arithmetic meaning of the operation for the 8-bit instance.
  function automatic logic [8:0] ref_sum(input logic [7:0] av, input logic [7:0] bv,
                                         input logic cv, input logic sv);
    int unsigned r;
    if (SUB_ON && sv) r = int'(av) + 256 - int'(bv);
    else              r = int'(av) + int'(bv) + int'(cv);
    return 9'(r % 512);
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      $error("[TB] assertion %s", tag);
    end
  endtask

  // One operation on the main instance, called at a negedge with the block in
  // IDLE. Checks busy/out_valid timing, holds the result for 'hold' cycles of
  // back-pressure while offering new operands, then completes the handshake.
  task automatic apply_stimulus(input logic [7:0] av, input logic [7:0] bv,
                                input logic cv, input logic sv, input int hold);
    logic [8:0] exp;
    exp      = ref_sum(av, bv, cv, sv);
    a        = av;
    b        = bv;
    cin      = cv;
    sub      = sv;
    in_valid = 1'b1;
    check_output("accept_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    a        = 8'($urandom);
    b        = 8'($urandom);
    cin      = 1'($urandom);
    check_output("busy_t0", 32'(busy), 32'd1);
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      check_output("busy_run", 32'(busy), 32'd1);
      check_output("no_early_valid", 32'(out_valid), 32'd0);
    end
    @(negedge clk);
    check_output("valid_latency", 32'(out_valid), 32'd1);
    check_output("busy_done", 32'(busy), 32'd0);
    check_output("ready_done", 32'(in_ready), 32'd0);
    check_output("sum", 32'(sum), 32'(exp));
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      a        = 8'($urandom);
      b        = 8'($urandom);
      @(negedge clk);
      check_output("hold_sum", 32'(sum), 32'(exp));
      check_output("hold_valid", 32'(out_valid), 32'd1);
      check_output("hold_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check_output("hs_valid_clr", 32'(out_valid), 32'd0);
    check_output("hs_ready", 32'(in_ready), 32'd1);
    check_output("hs_not_taken", 32'(busy), 32'd0);
  endtask

  initial begin
    int k;
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    a         = 8'hA5;
    b         = 8'h3C;
    cin       = 1'b1;
    sub       = 1'b0;
    out_ready = 1'b0;
    v2 = 1'b0; a2 = '0; b2 = '0; c2 = 1'b0; ordy2 = 1'b1;
    v4 = 1'b0; a4 = '0; b4 = '0; c4 = 1'b0; ordy4 = 1'b1;

    // Reset held for three cycles with in_valid asserted.
    repeat (3) @(negedge clk);
    check_output("rst_in_ready", 32'(in_ready), 32'd0);
    check_output("rst_out_valid", 32'(out_valid), 32'd0);
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_sum", 32'(sum), 32'd0);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    #1;
    check_output("post_rst_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    check_output("post_rst_idle", 32'(busy), 32'd0);
    check_output("post_rst_ready2", 32'(in_ready), 32'd1);

    // Directed adds.
    apply_stimulus(8'hFF, 8'h01, 1'b0, 1'b0, 0);
    apply_stimulus(8'h5A, 8'h3C, 1'b1, 1'b0, 0);

    // Back-pressure with new operands offered while DONE.
    apply_stimulus(8'hC3, 8'h7E, 1'b1, 1'b0, 5);

    // Reset pulse in the middle of an operation.
    a = 8'hF0; b = 8'h0F; cin = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_output("abort_valid", 32'(out_valid), 32'd0);
    check_output("abort_sum", 32'(sum), 32'd0);
    check_output("abort_busy", 32'(busy), 32'd0);
    check_output("abort_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check_output("abort_no_result", 32'(out_valid), 32'd0);
    check_output("abort_sum_zero", 32'(sum), 32'd0);
    apply_stimulus(8'h10, 8'h20, 1'b0, 1'b0, 0);

`ifdef CHUNKED_ADDER_SUB_EN
    apply_stimulus(8'h05, 8'h07, 1'b1, 1'b1, 0);
    apply_stimulus(8'h07, 8'h05, 1'b0, 1'b1, 0);
    apply_stimulus(8'h07, 8'h05, 1'b1, 1'b0, 0);
`endif

    // Randomized operations with random back-pressure.
    for (int i = 0; i < 30; i++) begin
      apply_stimulus(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
                     int'($urandom_range(0, 3)));
    end

    // Exhaustive WIDTH=2, CHUNK=1, back-to-back with out_ready held high.
    for (int i = 0; i < 32; i++) begin
      a2 = 2'(i);
      b2 = 2'(i >> 2);
      c2 = 1'(i >> 4);
      v2 = 1'b1;
      @(negedge clk);
      v2 = 1'b0;
      k  = 0;
      while (ov2 !== 1'b1 && k < 8) begin
        @(negedge clk);
        k++;
      end
      check_output("w2_valid", 32'(ov2), 32'd1);
      check_output("w2_sum", 32'(s2), 32'((i & 3) + ((i >> 2) & 3) + ((i >> 4) & 1)));
      @(negedge clk);
    end

    // Exhaustive WIDTH=4, CHUNK=4 (single-cycle RUN).
    for (int i = 0; i < 512; i++) begin
      a4 = 4'(i);
      b4 = 4'(i >> 4);
      c4 = 1'(i >> 8);
      v4 = 1'b1;
      @(negedge clk);
      v4 = 1'b0;
      k  = 0;
      while (ov4 !== 1'b1 && k < 8) begin
        @(negedge clk);
        k++;
      end
      check_output("w4_valid", 32'(ov4), 32'd1);
      check_output("w4_sum", 32'(s4), 32'((i & 15) + ((i >> 4) & 15) + ((i >> 8) & 1)));
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
